// File: rtl/opfetch_swc.sv
// opfetch_swc - operand-fetch stage in front of the register file.
//
// Takes a decoded instruction, drives both regfile read ports in the accept
// cycle, and captures the registered read data one cycle later. While
// capturing, it patches in any writeback the regfile read could not have seen.
// The finished operand bundle is held for execute over valid/ready. While the
// bundle waits, the writeback port keeps being snooped so the operands never
// go stale.
//
// Optional build macro OPF_BYPASS_CNT_EN:
//   When defined, adds stat_bypass_cnt. This counter advances once per cycle
//   in which any operand is taken from the writeback port.
//
// Ports:
//   hclk, hrstn                  clock, async active-low reset
//   flush                        synchronous pipeline kill
//   in_valid/in_ready            decoded-instruction handshake
//   in_pc, in_rs1, in_rs2,       instruction fields; the rd field is
//   in_use_rs1, in_use_rs2,      passed through unchanged
//   in_rd
//   reg_raddr_x, reg_ren_x       regfile read request (issued in accept cycle)
//   reg_rdata_x                  regfile read data, one cycle after ren
//   wb_wen, wb_waddr, wb_wdata   snooped writeback port
//   out_valid/out_ready          operand bundle handshake to execute
//   out_pc, out_rs1_val,         operand bundle
//   out_rs2_val, out_rd
//   stat_bypass_cnt              bypass statistics (OPF_BYPASS_CNT_EN only)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no instruction held; ready to accept
// READ  | regfile read in flight; capture operands (with bypass) this cycle
// HOLD  | bundle presented to execute; snoop writebacks until taken

module opfetch_swc #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              hclk,
   input  logic              hrstn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_pc,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic              in_use_rs1,
   input  logic              in_use_rs2,
   input  logic [ADDR_W-1:0] in_rd,
   output logic [ADDR_W-1:0] reg_raddr_1,
   output logic [ADDR_W-1:0] reg_raddr_2,
   output logic              reg_ren_1,
   output logic              reg_ren_2,
   input  logic [DATA_W-1:0] reg_rdata_1,
   input  logic [DATA_W-1:0] reg_rdata_2,
   input  logic              wb_wen,
   input  logic [ADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [DATA_W-1:0] out_rs1_val,
   output logic [DATA_W-1:0] out_rs2_val,
`ifdef OPF_BYPASS_CNT_EN
   output logic [31:0]       stat_bypass_cnt,
`endif
   output logic [ADDR_W-1:0] out_rd
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         pc_q, pc_d;
   logic [ADDR_W-1:0]   rs1_q, rs1_d;
   logic [ADDR_W-1:0]   rs2_q, rs2_d;
   logic                use1_q, use1_d;
   logic                use2_q, use2_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic [DATA_W-1:0]   val1_q, val1_d;
   logic [DATA_W-1:0]   val2_q, val2_d;

   logic                accept;
   logic                hit1, hit2;
   logic [DATA_W-1:0]   cap1, cap2;

   // in_ready deliberately ignores flush; flush only blocks the accept.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         S_IDLE:  in_ready = 1'b1;
         S_HOLD:  in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept      = in_valid && in_ready && !flush;
   assign reg_raddr_1 = in_rs1;
   assign reg_raddr_2 = in_rs2;
   assign reg_ren_1   = accept && in_use_rs1 && (in_rs1 != '0);
   assign reg_ren_2   = accept && in_use_rs2 && (in_rs2 != '0);

   // A writeback hit only counts for a live, non-x0 source, so waddr 0 is
   // never forwarded.
   assign hit1 = wb_wen && (wb_waddr == rs1_q) && (rs1_q != '0) && use1_q;
   assign hit2 = wb_wen && (wb_waddr == rs2_q) && (rs2_q != '0) && use2_q;

   assign cap1 = hit1 ? wb_wdata : ((use1_q && (rs1_q != '0)) ? reg_rdata_1 : '0);
   assign cap2 = hit2 ? wb_wdata : ((use2_q && (rs2_q != '0)) ? reg_rdata_2 : '0);

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (accept) state_d = S_READ;
            S_READ: state_d = S_HOLD;
            S_HOLD: begin
               if (out_ready) state_d = accept ? S_READ : S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      pc_d   = pc_q;
      rs1_d  = rs1_q;
      rs2_d  = rs2_q;
      use1_d = use1_q;
      use2_d = use2_q;
      rd_d   = rd_q;
      val1_d = val1_q;
      val2_d = val2_q;
      if (accept) begin
         pc_d   = in_pc;
         rs1_d  = in_rs1;
         rs2_d  = in_rs2;
         use1_d = in_use_rs1;
         use2_d = in_use_rs2;
         rd_d   = in_rd;
      end
      // On flush the operand registers keep their old contents.
      if (!flush) begin
         if (state_q == S_READ) begin
            val1_d = cap1;
            val2_d = cap2;
         end else if (state_q == S_HOLD) begin
            if (hit1) val1_d = wb_wdata;
            if (hit2) val2_d = wb_wdata;
         end
      end
   end

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         use1_q  <= 1'b0;
         use2_q  <= 1'b0;
         rd_q    <= '0;
         val1_q  <= '0;
         val2_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         use1_q  <= use1_d;
         use2_q  <= use2_d;
         rd_q    <= rd_d;
         val1_q  <= val1_d;
         val2_q  <= val2_d;
      end
   end

   assign out_valid   = (state_q == S_HOLD);
   assign out_pc      = pc_q;
   assign out_rd      = rd_q;
   assign out_rs1_val = val1_q;
   assign out_rs2_val = val2_q;

`ifdef OPF_BYPASS_CNT_EN
   logic        byp_take;
   logic [31:0] cnt_q;

   // Counts once per cycle even when both operands bypass; wraps naturally.
   assign byp_take = !flush && ((state_q == S_READ) || (state_q == S_HOLD)) &&
                     (hit1 || hit2);

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn)        cnt_q <= '0;
      else if (byp_take) cnt_q <= cnt_q + 32'd1;
   end

   assign stat_bypass_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_opfetch_swc.sv
module tb_opfetch_swc;

   logic        hclk = 1'b0;
   logic        hrstn;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_use_rs1, in_use_rs2;
   logic [4:0]  reg_raddr_1, reg_raddr_2;
   logic        reg_ren_1, reg_ren_2;
   logic [31:0] reg_rdata_1, reg_rdata_2;
   logic        wb_wen;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc, out_rs1_val, out_rs2_val;
   logic [4:0]  out_rd;
`ifdef OPF_BYPASS_CNT_EN
   logic [31:0] stat_bypass_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 hclk = ~hclk;

   opfetch_swc #(.DATA_W(32), .ADDR_W(5)) dut (
      .hclk        (hclk),
      .hrstn       (hrstn),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pc       (in_pc),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_use_rs1  (in_use_rs1),
      .in_use_rs2  (in_use_rs2),
      .in_rd       (in_rd),
      .reg_raddr_1 (reg_raddr_1),
      .reg_raddr_2 (reg_raddr_2),
      .reg_ren_1   (reg_ren_1),
      .reg_ren_2   (reg_ren_2),
      .reg_rdata_1 (reg_rdata_1),
      .reg_rdata_2 (reg_rdata_2),
      .wb_wen      (wb_wen),
      .wb_waddr    (wb_waddr),
      .wb_wdata    (wb_wdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_rs1_val (out_rs1_val),
      .out_rs2_val (out_rs2_val),
`ifdef OPF_BYPASS_CNT_EN
      .stat_bypass_cnt (stat_bypass_cnt),
`endif
      .out_rd      (out_rd)
   );

   // Register file environment: registered reads with write-first forwarding.
   logic [31:0] mem [32];
   always @(posedge hclk) begin
      if (reg_ren_1)
         reg_rdata_1 <= (wb_wen && wb_waddr != 0 && wb_waddr == reg_raddr_1) ? wb_wdata : mem[reg_raddr_1];
      if (reg_ren_2)
         reg_rdata_2 <= (wb_wen && wb_waddr != 0 && wb_waddr == reg_raddr_2) ? wb_wdata : mem[reg_raddr_2];
      if (wb_wen && wb_waddr != 0)
         mem[wb_waddr] <= wb_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic wb_load(input logic [4:0] a, input logic [31:0] d);
      @(negedge hclk);
      wb_wen = 1'b1; wb_waddr = a; wb_wdata = d;
      @(negedge hclk);
      wb_wen = 1'b0;
   endtask

   task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2,
                              input logic [31:0] pc, input logic [4:0] rd);
      in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2;
      in_use_rs1 = u1; in_use_rs2 = u2; in_pc = pc; in_rd = rd;
   endtask

   typedef struct {
      logic [4:0]  rs1, rs2;
      logic        u1, u2;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        wen;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ren1, ren2;
      logic [31:0] v1, v2;
      int          byp;
   } vec_t;

   vec_t tbl [6];
   int   exp_cnt;

   // Reference model state for the random phase
   logic        m_v;
   int          m_age;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic        m_u1, m_u2;
   logic [31:0] m_pc;

   initial begin
      logic exp_rdy, exp_ov, acc, e1, e2;
      int   nacc;

      hrstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0;
      in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_use_rs1 = 1'b0; in_use_rs2 = 1'b0;
      wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0; out_ready = 1'b0;
      exp_cnt = 0;

      //           rs1 rs2 u1 u2 pc        rd  wen wa  wd              ren1 ren2 v1              v2              byp
      tbl[0] = '{5'd5, 5'd6, 1, 1, 32'h100, 5'd7, 0, 5'd0, 32'h0,      1, 1, 32'h11,     32'h22,     0};
      tbl[1] = '{5'd0, 5'd3, 1, 0, 32'h104, 5'd1, 0, 5'd0, 32'h0,      0, 0, 32'h0,      32'h0,      0};
      tbl[2] = '{5'd4, 5'd5, 1, 1, 32'h108, 5'd2, 1, 5'd4, 32'hDEAD,   1, 1, 32'hDEAD,   32'h11,     1};
      tbl[3] = '{5'd3, 5'd3, 1, 1, 32'h10C, 5'd3, 1, 5'd3, 32'h77,     1, 1, 32'h77,     32'h77,     1};
      tbl[4] = '{5'd0, 5'd9, 1, 1, 32'h110, 5'd4, 1, 5'd0, 32'hFFFF,   0, 1, 32'h0,      32'h99,     0};
      tbl[5] = '{5'd6, 5'd4, 0, 1, 32'h114, 5'd5, 1, 5'd6, 32'h66,     0, 1, 32'h0,      32'hDEAD,   0};

      #2;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_rs1", out_rs1_val, 32'd0);
      chk("rst_out_rs2", out_rs2_val, 32'd0);
      chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
      chk("rst_ren", {30'd0, reg_ren_1, reg_ren_2}, 32'd0);
`ifdef OPF_BYPASS_CNT_EN
      chk("rst_cnt", stat_bypass_cnt, 32'd0);
`endif
      @(negedge hclk);
      hrstn = 1'b1;

      wb_load(5'd3, 32'h33);
      wb_load(5'd4, 32'h44);
      wb_load(5'd5, 32'h11);
      wb_load(5'd6, 32'h22);
      wb_load(5'd9, 32'h99);

      // Table-driven single transactions with optional writeback in READ
      for (int i = 0; i < 6; i++) begin
         @(negedge hclk);
         drive_instr(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].pc, tbl[i].rd);
         out_ready = 1'b0;
         #1;
         chk($sformatf("t%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
         chk($sformatf("t%0d_ren1", i), {31'd0, reg_ren_1}, {31'd0, tbl[i].ren1});
         chk($sformatf("t%0d_ren2", i), {31'd0, reg_ren_2}, {31'd0, tbl[i].ren2});
         if (tbl[i].ren1) chk($sformatf("t%0d_raddr1", i), {27'd0, reg_raddr_1}, {27'd0, tbl[i].rs1});
         if (tbl[i].ren2) chk($sformatf("t%0d_raddr2", i), {27'd0, reg_raddr_2}, {27'd0, tbl[i].rs2});
         @(negedge hclk);
         in_valid = 1'b0;
         wb_wen = tbl[i].wen; wb_waddr = tbl[i].wa; wb_wdata = tbl[i].wd;
         #1;
         chk($sformatf("t%0d_read_rdy", i), {31'd0, in_ready}, 32'd0);
         chk($sformatf("t%0d_read_ov", i), {31'd0, out_valid}, 32'd0);
         @(negedge hclk);
         wb_wen = 1'b0;
         #1;
         chk($sformatf("t%0d_ov", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("t%0d_v1", i), out_rs1_val, tbl[i].v1);
         chk($sformatf("t%0d_v2", i), out_rs2_val, tbl[i].v2);
         chk($sformatf("t%0d_pc", i), out_pc, tbl[i].pc);
         chk($sformatf("t%0d_rd", i), {27'd0, out_rd}, {27'd0, tbl[i].rd});
         exp_cnt += tbl[i].byp;
         out_ready = 1'b1;
         @(negedge hclk);
         out_ready = 1'b0;
         #1;
         chk($sformatf("t%0d_drained", i), {31'd0, out_valid}, 32'd0);
      end

      // Stall in HOLD for three cycles with a snooped write in the second
      @(negedge hclk);
      drive_instr(5'd4, 5'd5, 1'b1, 1'b1, 32'h200, 5'd9);
      @(negedge hclk);
      in_valid = 1'b0;
      @(negedge hclk);
      #1;
      chk("hold1_ov", {31'd0, out_valid}, 32'd1);
      chk("hold1_v1", out_rs1_val, 32'hDEAD);
      @(negedge hclk);
      wb_wen = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'hBEEF;
      #1;
      chk("hold2_ov", {31'd0, out_valid}, 32'd1);
      chk("hold2_v1", out_rs1_val, 32'hDEAD);
      @(negedge hclk);
      wb_wen = 1'b0;
      #1;
      chk("hold3_ov", {31'd0, out_valid}, 32'd1);
      chk("hold3_v1", out_rs1_val, 32'hBEEF);
      chk("hold3_v2", out_rs2_val, 32'h11);
      chk("hold3_pc", out_pc, 32'h200);
      chk("hold3_rd", {27'd0, out_rd}, 32'd9);
      exp_cnt += 1;
      out_ready = 1'b1;
      @(negedge hclk);
      out_ready = 1'b0;
`ifdef OPF_BYPASS_CNT_EN
      #1;
      chk("bypass_cnt", stat_bypass_cnt, exp_cnt);
`endif

      // Back-to-back: one bundle every two cycles, in order
      nacc = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge hclk);
         drive_instr(5'd5, 5'd0, 1'b1, 1'b0, 32'h300 + 32'(4 * nacc), 5'(10 + nacc));
         out_ready = 1'b1;
         #1;
         chk($sformatf("b2b%0d_rdy", c), {31'd0, in_ready}, {31'd0, (c % 2) == 0});
         chk($sformatf("b2b%0d_ov", c), {31'd0, out_valid}, {31'd0, (c >= 2) && ((c % 2) == 0)});
         if (c >= 2 && (c % 2) == 0) begin
            chk($sformatf("b2b%0d_pc", c), out_pc, 32'h300 + 32'(4 * (nacc - 1)));
            chk($sformatf("b2b%0d_rd", c), {27'd0, out_rd}, 32'(10 + nacc - 1));
            chk($sformatf("b2b%0d_v1", c), out_rs1_val, 32'h11);
         end
         if ((c % 2) == 0) nacc++;
      end
      @(negedge hclk);
      in_valid = 1'b0;
      #1;
      chk("b2b_last_ov", {31'd0, out_valid}, 32'd1);
      chk("b2b_last_pc", out_pc, 32'h30C);
      @(negedge hclk);
      out_ready = 1'b0;

      // Flush while in READ, then flush blocks an accept in IDLE
      @(negedge hclk);
      drive_instr(5'd5, 5'd6, 1'b1, 1'b1, 32'h500, 5'd3);
      @(negedge hclk);
      in_valid = 1'b0; flush = 1'b1;
      @(negedge hclk);
      drive_instr(5'd5, 5'd6, 1'b1, 1'b1, 32'h504, 5'd4);
      #1;
      chk("flush_ov", {31'd0, out_valid}, 32'd0);
      chk("flush_rdy", {31'd0, in_ready}, 32'd1);
      chk("flush_ren1", {31'd0, reg_ren_1}, 32'd0);
      @(negedge hclk);
      in_valid = 1'b0; flush = 1'b0;
      #1;
      chk("flush_idle_rdy", {31'd0, in_ready}, 32'd1);
      chk("flush_idle_ov", {31'd0, out_valid}, 32'd0);

      // Reset asserted while holding a bundle
      @(negedge hclk);
      drive_instr(5'd5, 5'd6, 1'b1, 1'b1, 32'h400, 5'd5);
      @(negedge hclk);
      in_valid = 1'b0;
      @(negedge hclk);
      #1;
      chk("rhold_ov", {31'd0, out_valid}, 32'd1);
      hrstn = 1'b0;
      #1;
      chk("rmid_ov", {31'd0, out_valid}, 32'd0);
      chk("rmid_pc", out_pc, 32'd0);
      chk("rmid_v1", out_rs1_val, 32'd0);
      chk("rmid_v2", out_rs2_val, 32'd0);
      chk("rmid_rd", {27'd0, out_rd}, 32'd0);
      chk("rmid_rdy", {31'd0, in_ready}, 32'd1);
`ifdef OPF_BYPASS_CNT_EN
      chk("rmid_cnt", stat_bypass_cnt, 32'd0);
`endif
      @(negedge hclk);
      hrstn = 1'b1;

      // Random phase against a slot/age model and architectural register state
      for (int r = 1; r < 32; r++) wb_load(5'(r), $urandom);
      m_v = 1'b0; m_age = 0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_u1 = 1'b0; m_u2 = 1'b0; m_pc = '0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge hclk);
         in_valid   = ($urandom_range(0, 9) < 7);
         in_rs1     = 5'($urandom_range(0, 7));
         in_rs2     = 5'($urandom_range(0, 7));
         in_use_rs1 = 1'($urandom_range(0, 1));
         in_use_rs2 = 1'($urandom_range(0, 1));
         in_pc      = $urandom;
         in_rd      = 5'($urandom_range(0, 31));
         flush      = ($urandom_range(0, 31) == 0);
         out_ready  = ($urandom_range(0, 9) < 6);
         wb_wen     = ($urandom_range(0, 9) < 4);
         wb_waddr   = 5'($urandom_range(0, 7));
         wb_wdata   = $urandom;
         #1;
         exp_rdy = !m_v || (m_age == 2 && out_ready);
         exp_ov  = m_v && (m_age == 2);
         acc     = in_valid && exp_rdy && !flush;
         e1      = acc && in_use_rs1 && (in_rs1 != 0);
         e2      = acc && in_use_rs2 && (in_rs2 != 0);
         chk("rnd_rdy", {31'd0, in_ready}, {31'd0, exp_rdy});
         chk("rnd_ov", {31'd0, out_valid}, {31'd0, exp_ov});
         chk("rnd_ren1", {31'd0, reg_ren_1}, {31'd0, e1});
         chk("rnd_ren2", {31'd0, reg_ren_2}, {31'd0, e2});
         if (e1) chk("rnd_raddr1", {27'd0, reg_raddr_1}, {27'd0, in_rs1});
         if (e2) chk("rnd_raddr2", {27'd0, reg_raddr_2}, {27'd0, in_rs2});
         if (exp_ov) begin
            chk("rnd_pc", out_pc, m_pc);
            chk("rnd_rd", {27'd0, out_rd}, {27'd0, m_rd});
            chk("rnd_v1", out_rs1_val, (m_u1 && m_rs1 != 0) ? mem[m_rs1] : 32'd0);
            chk("rnd_v2", out_rs2_val, (m_u2 && m_rs2 != 0) ? mem[m_rs2] : 32'd0);
         end
         if (flush) begin
            m_v = 1'b0;
         end else if (acc) begin
            m_v = 1'b1; m_age = 1;
            m_rs1 = in_rs1; m_rs2 = in_rs2; m_u1 = in_use_rs1; m_u2 = in_use_rs2;
            m_pc = in_pc; m_rd = in_rd;
         end else if (m_v && m_age == 2 && out_ready) begin
            m_v = 1'b0;
         end else if (m_v) begin
            m_age = 2;
         end
      end

      @(negedge hclk);
      in_valid = 1'b0; flush = 1'b0; wb_wen = 1'b0; out_ready = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
